ysyx_210184_clint: RTL and testbench

Core-local interruptor and memory-mapped timer. It sits on the responder side of the core's simple memory-access bus (`r_ena`/`w_ena`/`addr`/`w_data`/`w_mask`, answered by `r_data` plus `r_ready`/`w_ready`). It owns `msip`, `mtimecmp` and a free-running `mtime`, and drives the core's `mtime_intr` and `software_intr` inputs. Requests whose address falls outside its window are ignored, so another responder can serve them.

---
 rtl/ysyx_210184_clint.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_210184_clint.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_210184_clint.sv
// Core-local interruptor: msip, mtimecmp and a prescaled free-running mtime
// served as a responder on the core's request/ready memory-access bus.
module ysyx_210184_clint #(
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_0200_0000,
  parameter int unsigned TICK_DIV  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        r_ena,
  input  logic        w_ena,
  input  logic [63:0] addr,
  input  logic [63:0] w_data,
  input  logic [63:0] w_mask,
  output logic [63:0] r_data,
  output logic        r_ready,
  output logic        w_ready,
  output logic        mtime_intr,
  output logic        software_intr
);

  localparam int unsigned DW = 64;
  localparam int unsigned IW = 13;
  localparam int unsigned PW = 16;

  localparam logic [DW-1:0] WIN_SIZE     = 64'h0000_0000_0001_0000;
  localparam logic [IW-1:0] IDX_MSIP     = 13'h0000;
  localparam logic [IW-1:0] IDX_MTIMECMP = 13'h0800;
  localparam logic [IW-1:0] IDX_MTIME    = 13'h17FF;
  localparam logic [PW-1:0] PRESC_MAX    = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RESP = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic            is_wr_q, is_wr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [DW-1:0]   wmask_q, wmask_d;
  logic [DW-1:0]   r_data_q, r_data_d;
  logic            r_ready_q, r_ready_d;
  logic            w_ready_q, w_ready_d;
  logic            msip_q, msip_d;
  logic [DW-1:0]   mtimecmp_q, mtimecmp_d;
  logic [DW-1:0]   mtime_q, mtime_d;
  logic [PW-1:0]   presc_q, presc_d;
  logic            intr_q, intr_d;

  logic [DW-1:0]   offset_c;
  logic [DW-1:0]   rd_val_c;
  logic [IW-1:0]   req_idx_c;
  logic            hit_c;
  logic            req_c;
  logic            tick_c;
  logic            commit_c;

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur,
                                          input logic [DW-1:0] data,
                                          input logic [DW-1:0] mask);
    return (cur & ~mask) | (data & mask);
  endfunction

  // Unsigned offset compare covers both window bounds in one test.
  assign offset_c  = addr - BASE_ADDR;
  assign hit_c     = offset_c < WIN_SIZE;
  assign req_c     = (r_ena | w_ena) & hit_c;
  assign req_idx_c = offset_c[15:3];
  assign tick_c    = presc_q == PRESC_MAX;
  assign commit_c  = (state_q == RESP) & is_wr_q;

  always_comb begin
    rd_val_c = '0;
    case (req_idx_c)
      IDX_MSIP:     rd_val_c = DW'(msip_q);
      IDX_MTIMECMP: rd_val_c = mtimecmp_q;
      IDX_MTIME:    rd_val_c = mtime_q;
      default:      rd_val_c = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_c) state_d = RESP;
      RESP:    state_d = DONE;
      DONE:    if (!r_ena && !w_ena) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    is_wr_d    = is_wr_q;
    idx_d      = idx_q;
    wdata_d    = wdata_q;
    wmask_d    = wmask_q;
    r_data_d   = r_data_q;
    r_ready_d  = 1'b0;
    w_ready_d  = 1'b0;
    msip_d     = msip_q;
    mtimecmp_d = mtimecmp_q;
    mtime_d    = mtime_q;
    presc_d    = presc_q;
    intr_d     = mtime_q >= mtimecmp_q;

    // Capture the request; a simultaneous read and write is treated as a write.
    if (state_q == IDLE && req_c) begin
      is_wr_d = w_ena;
      idx_d   = req_idx_c;
      wdata_d = w_data;
      wmask_d = w_mask;
      if (w_ena) begin
        w_ready_d = 1'b1;
      end else begin
        r_ready_d = 1'b1;
        r_data_d  = rd_val_c;
      end
    end

    if (tick_c) begin
      presc_d = '0;
      mtime_d = mtime_q + 64'd1;
    end else begin
      presc_d = presc_q + PW'(1);
    end

    // A software write to mtime overrides the tick increment on the same edge.
    if (commit_c) begin
      case (idx_q)
        IDX_MSIP:     msip_d = (msip_q & ~wmask_q[0]) | (wdata_q[0] & wmask_q[0]);
        IDX_MTIMECMP: mtimecmp_d = merge(mtimecmp_q, wdata_q, wmask_q);
        IDX_MTIME:    mtime_d = merge(mtime_q, wdata_q, wmask_q);
        default:      ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      is_wr_q    <= 1'b0;
      idx_q      <= '0;
      wdata_q    <= '0;
      wmask_q    <= '0;
      r_data_q   <= '0;
      r_ready_q  <= 1'b0;
      w_ready_q  <= 1'b0;
      msip_q     <= 1'b0;
      mtimecmp_q <= '1;
      mtime_q    <= '0;
      presc_q    <= '0;
      intr_q     <= 1'b0;
    end else begin
      is_wr_q    <= is_wr_d;
      idx_q      <= idx_d;
      wdata_q    <= wdata_d;
      wmask_q    <= wmask_d;
      r_data_q   <= r_data_d;
      r_ready_q  <= r_ready_d;
      w_ready_q  <= w_ready_d;
      msip_q     <= msip_d;
      mtimecmp_q <= mtimecmp_d;
      mtime_q    <= mtime_d;
      presc_q    <= presc_d;
      intr_q     <= intr_d;
    end
  end

  assign r_data        = r_data_q;
  assign r_ready       = r_ready_q;
  assign w_ready       = w_ready_q;
  assign mtime_intr    = intr_q;
  assign software_intr = msip_q;

endmodule

// File: tb/tb_ysyx_210184_clint.sv
// Scoreboard bench for the CLINT: two instances (TICK_DIV 1 and 4) share one bus;
// a closed-form timer model predicts read data and interrupt levels.
module tb_ysyx_210184_clint;

  localparam logic [63:0] BASE       = 64'h0000_0000_0200_0000;
  localparam logic [63:0] WIN        = 64'h0000_0000_0001_0000;
  localparam logic [63:0] OFF_MSIP   = 64'h0;
  localparam logic [63:0] OFF_CMP    = 64'h4000;
  localparam logic [63:0] OFF_MTIME  = 64'hBFF8;
  localparam int          NI         = 2;

  typedef struct packed {
    logic        wr;
    logic [63:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        r_ena = 1'b0;
  logic        w_ena = 1'b0;
  logic [63:0] addr = '0;
  logic [63:0] w_data = '0;
  logic [63:0] w_mask = '0;
  logic [63:0] r_data [NI];
  logic        r_ready [NI];
  logic        w_ready [NI];
  logic        mtime_intr [NI];
  logic        software_intr [NI];

  ysyx_210184_clint #(.BASE_ADDR(BASE), .TICK_DIV(1)) u_div1 (
    .clk(clk), .rst(rst), .r_ena(r_ena), .w_ena(w_ena), .addr(addr),
    .w_data(w_data), .w_mask(w_mask), .r_data(r_data[0]), .r_ready(r_ready[0]),
    .w_ready(w_ready[0]), .mtime_intr(mtime_intr[0]), .software_intr(software_intr[0])
  );

  ysyx_210184_clint #(.BASE_ADDR(BASE), .TICK_DIV(4)) u_div4 (
    .clk(clk), .rst(rst), .r_ena(r_ena), .w_ena(w_ena), .addr(addr),
    .w_data(w_data), .w_mask(w_mask), .r_data(r_data[1]), .r_ready(r_ready[1]),
    .w_ready(w_ready[1]), .mtime_intr(mtime_intr[1]), .software_intr(software_intr[1])
  );

  always #5 clk = ~clk;

  // Number of rising edges seen since reset was released.
  int ec = 0;
  always @(posedge clk or negedge rst) begin
    if (!rst) ec <= 0;
    else      ec <= ec + 1;
  end

  int checks = 0;
  int errors = 0;

  // Model: each register value is known as "value after edge E" with one level of history.
  logic [63:0] ld_v [NI];
  logic [63:0] ld_v_prev [NI];
  int          ld_e [NI];
  int          ld_e_prev [NI];
  logic [63:0] cmp_v, cmp_prev;
  int          cmp_e;
  logic        msip_v, msip_prev;
  int          msip_e;
  logic [63:0] last_rd [NI];
  exp_t        sbq0 [$];
  exp_t        sbq1 [$];

  function automatic int td(input int i);
    return (i == 0) ? 1 : 4;
  endfunction

  // mtime ticks on every edge number that is a multiple of TICK_DIV, except a load edge.
  function automatic logic [63:0] mtime_at(input int i, input int e);
    if (e >= ld_e[i]) return ld_v[i] + 64'(e / td(i) - ld_e[i] / td(i));
    return ld_v_prev[i] + 64'(e / td(i) - ld_e_prev[i] / td(i));
  endfunction

  function automatic logic [63:0] cmp_at(input int e);
    return (e >= cmp_e) ? cmp_v : cmp_prev;
  endfunction

  function automatic logic msip_at(input int e);
    return (e >= msip_e) ? msip_v : msip_prev;
  endfunction

  function automatic logic [63:0] read_model(input int i, input logic [63:0] off, input int e);
    if (off == OFF_MSIP)  return 64'(msip_at(e));
    if (off == OFF_CMP)   return cmp_at(e);
    if (off == OFF_MTIME) return mtime_at(i, e);
    return 64'h0;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    if (i == 0) sbq0.push_back(e);
    else        sbq1.push_back(e);
  endtask

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      ld_v[i] = '0; ld_v_prev[i] = '0; ld_e[i] = 0; ld_e_prev[i] = 0; last_rd[i] = '0;
    end
    cmp_v = '1; cmp_prev = '1; cmp_e = 0;
    msip_v = 1'b0; msip_prev = 1'b0; msip_e = 0;
    sbq0.delete();
    sbq1.delete();
  endtask

  task automatic check_reset_outputs();
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("rst_r_data%0d", i), r_data[i], 64'h0);
      chk($sformatf("rst_ready%0d", i), 64'({r_ready[i], w_ready[i]}), 64'h0);
      chk($sformatf("rst_intr%0d", i), 64'({mtime_intr[i], software_intr[i]}), 64'h0);
    end
  endtask

  // Monitor: pops the scoreboard on every ready pulse and checks interrupt levels each cycle.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    logic exp_intr;
    if (rst) begin
      for (int i = 0; i < NI; i++) begin
        if (r_ready[i] || w_ready[i]) begin
          have = 1'b0;
          e = '0;
          if (i == 0 && sbq0.size() > 0) begin have = 1'b1; e = sbq0.pop_front(); end
          if (i == 1 && sbq1.size() > 0) begin have = 1'b1; e = sbq1.pop_front(); end
          if (!have) begin
            checks++;
            errors++;
            $display("FAIL unexpected_ready inst%0d at %0t: got r_ready=%0b w_ready=%0b required none",
                     i, $time, r_ready[i], w_ready[i]);
          end else begin
            chk($sformatf("ready_kind%0d", i), 64'({r_ready[i], w_ready[i]}), 64'({~e.wr, e.wr}));
            chk($sformatf("r_data%0d", i), r_data[i], e.data);
          end
        end
        exp_intr = (ec == 0) ? 1'b0 : (mtime_at(i, ec - 1) >= cmp_at(ec - 1));
        chk($sformatf("mtime_intr%0d", i), 64'(mtime_intr[i]), 64'(exp_intr));
        chk($sformatf("software_intr%0d", i), 64'(software_intr[i]), 64'(msip_at(ec)));
      end
    end
  end

  task automatic xact(input logic rd, input logic wr, input logic [63:0] a,
                      input logic [63:0] d, input logic [63:0] m, input int hold);
    int          n;
    int          seen;
    logic        hit;
    logic        cur1;
    logic [63:0] off;
    logic [63:0] cur;
    exp_t        e;
    hit = (a >= BASE) && (a < BASE + WIN);
    off = (a - BASE) & ~64'h7;
    @(negedge clk);
    r_ena = rd; w_ena = wr; addr = a; w_data = d; w_mask = m;
    @(posedge clk);
    #1;
    n = ec;
    if (hit && wr) begin
      for (int i = 0; i < NI; i++) begin
        e.wr = 1'b1; e.data = last_rd[i];
        push(i, e);
      end
      if (off == OFF_MSIP) begin
        cur1 = msip_at(n); msip_prev = cur1;
        msip_v = (cur1 & ~m[0]) | (d[0] & m[0]); msip_e = n + 1;
      end else if (off == OFF_CMP) begin
        cur = cmp_at(n); cmp_prev = cur;
        cmp_v = (cur & ~m) | (d & m); cmp_e = n + 1;
      end else if (off == OFF_MTIME) begin
        for (int i = 0; i < NI; i++) begin
          cur = mtime_at(i, n);
          ld_v_prev[i] = ld_v[i]; ld_e_prev[i] = ld_e[i];
          ld_v[i] = (cur & ~m) | (d & m); ld_e[i] = n + 1;
        end
      end
    end else if (hit && rd) begin
      for (int i = 0; i < NI; i++) begin
        e.wr = 1'b0; e.data = read_model(i, off, n - 1);
        push(i, e);
        last_rd[i] = e.data;
      end
    end
    seen = 0;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if (k == 0)
        chk("ready_latency", 64'({r_ready[0] | w_ready[0], r_ready[1] | w_ready[1]}),
            hit ? 64'h3 : 64'h0);
      for (int i = 0; i < NI; i++) seen += int'(r_ready[i]) + int'(w_ready[i]);
    end
    r_ena = 1'b0; w_ena = 1'b0;
    if (hold > 1) chk("ready_count", 64'(seen), hit ? 64'(NI) : 64'h0);
    repeat (2) @(posedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  initial begin
    logic [63:0] a;
    logic [63:0] d;
    logic [63:0] m;
    int          tgt;
    int          op;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    #1 rst = 1'b1;

    // Reset value of mtimecmp, then no timer interrupt for a long idle stretch.
    xact(1'b1, 1'b0, BASE + OFF_CMP, '0, '0, 1);
    chk("cmp_reset_read", r_data[0], 64'hFFFF_FFFF_FFFF_FFFF);
    repeat (200) @(negedge clk);

    // Timer interrupt rises at mtime == 0x40 and drops after mtimecmp is raised.
    xact(1'b0, 1'b1, BASE + OFF_MTIME, 64'h0, '1, 1);
    xact(1'b0, 1'b1, BASE + OFF_CMP, 64'h40, '1, 1);
    repeat (300) @(negedge clk);
    chk("intr_high_div4", 64'(mtime_intr[1]), 64'h1);
    xact(1'b0, 1'b1, BASE + OFF_CMP, '1, '1, 1);
    repeat (3) @(negedge clk);
    chk("intr_dropped", 64'({mtime_intr[0], mtime_intr[1]}), 64'h0);

    // msip set, masked-off write leaves it, readback.
    xact(1'b0, 1'b1, BASE + OFF_MSIP, 64'h1, 64'hFF, 1);
    xact(1'b0, 1'b1, BASE + OFF_MSIP, 64'h0, 64'h0, 1);
    xact(1'b1, 1'b0, BASE + OFF_MSIP, '0, '0, 1);
    chk("msip_read", r_data[0], 64'h1);

    // Partial-mask write of mtimecmp after reset.
    do_reset();
    xact(1'b0, 1'b1, BASE + OFF_CMP, 64'h1234_5678, 64'h0000_0000_FFFF_FFFF, 1);
    xact(1'b1, 1'b0, BASE + OFF_CMP, '0, '0, 1);
    chk("cmp_partial", r_data[1], 64'hFFFF_FFFF_1234_5678);

    // mtime wrap, and a load landing on a TICK_DIV=4 tick edge.
    xact(1'b0, 1'b1, BASE + OFF_MTIME, 64'hFFFF_FFFF_FFFF_FFFE, '1, 1);
    @(negedge clk);
    xact(1'b1, 1'b0, BASE + OFF_MTIME, '0, '0, 1);
    chk("mtime_wrap", r_data[0], 64'h0);
    do begin
      @(posedge clk);
      #1;
    end while ((ec + 2) % 4 != 0);
    xact(1'b0, 1'b1, BASE + OFF_MTIME, 64'h100, '1, 1);
    xact(1'b1, 1'b0, BASE + OFF_MTIME, '0, '0, 1);
    chk("mtime_load_on_tick", r_data[1], 64'h100);

    // Held request, misses on both sides of the window, write-wins, unmapped offset.
    xact(1'b1, 1'b0, BASE + OFF_MTIME, '0, '0, 6);
    xact(1'b1, 1'b0, BASE + WIN, '0, '0, 20);
    xact(1'b0, 1'b1, BASE - 64'h8, '1, '1, 20);
    xact(1'b1, 1'b1, BASE + OFF_CMP, 64'h55, '1, 1);
    xact(1'b0, 1'b1, BASE + 64'h10, '1, '1, 1);
    xact(1'b1, 1'b0, BASE + 64'h10, '0, '0, 1);

    // Reset during RESP with msip set, interrupt active and nonzero r_data.
    xact(1'b0, 1'b1, BASE + OFF_MSIP, 64'h1, 64'h1, 1);
    xact(1'b0, 1'b1, BASE + OFF_CMP, 64'h0, '1, 1);
    xact(1'b1, 1'b0, BASE + OFF_MTIME, '0, '0, 1);
    @(negedge clk);
    w_ena = 1'b1; addr = BASE + OFF_CMP; w_data = '1; w_mask = '1;
    @(posedge clk);
    #2 rst = 1'b0;
    #1 check_reset_outputs();
    w_ena = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
    xact(1'b1, 1'b0, BASE + OFF_CMP, '0, '0, 1);

    // Randomized traffic against the model.
    for (int t = 0; t < 200; t++) begin
      tgt = int'($urandom_range(0, 5));
      op  = int'($urandom_range(0, 2));
      d   = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 2000)) : {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0:       m = 64'h0;
        1:       m = {$urandom, $urandom};
        default: m = '1;
      endcase
      case (tgt)
        0:       a = BASE + OFF_MSIP;
        1:       a = BASE + OFF_CMP;
        2:       a = BASE + OFF_MTIME;
        3:       a = BASE + 64'({$urandom_range(0, 8191), 3'b000});
        4:       a = BASE + WIN + 64'($urandom_range(0, 4095));
        default: a = BASE - 64'($urandom_range(1, 4096));
      endcase
      a = a | 64'($urandom_range(0, 7));
      xact(op != 1, op != 0, a, d, m, (tgt >= 4) ? 3 : int'($urandom_range(1, 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq0.size() + sbq1.size()), 64'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
